// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the single CSR register port between the host
// AXI-lite bridge (requester 0) and the dataplane engine (requester 1).
// Round-robin grant, one transaction in flight, bounded wait for completion
// with an error response on timeout.
// Optional statistics counters are enabled by defining CSR_ARB_STATS_EN.
module csr_access_arbiter #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   waddr,
    output logic [DATA_W-1:0]   wdata,
    output logic                we,
    output logic [ADDR_W-1:0]   raddr,
    output logic                re,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rdone,
    input  logic                wdone
`ifdef CSR_ARB_STATS_EN
    ,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1,
    output logic [15:0]         timeout_cnt
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                write_q, write_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [1:0]          grant_c;
    logic                grant_wr_c;
    logic                done_match_c;
    logic                timeout_c;

    // Round-robin arbitration; only offered while idle and out of reset
    always_comb begin
        grant_c = 2'b00;
        if (state_q == S_IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
    end

    assign grant_wr_c   = grant_c[1] ? req_write[1] : req_write[0];
    assign done_match_c = write_q ? wdone : rdone;
    assign timeout_c    = TO_EN && (state_q == S_WAIT) && !done_match_c &&
                          (cnt_q == CNT_W'(TIMEOUT));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_c != 2'b00) begin
                    owner_d = grant_c[1];
                    write_d = grant_wr_c;
                    addr_d  = grant_c[1] ? req_addr[2*ADDR_W-1:ADDR_W]
                                         : req_addr[ADDR_W-1:0];
                    wdata_d = grant_c[1] ? req_wdata[2*DATA_W-1:DATA_W]
                                         : req_wdata[DATA_W-1:0];
                    last_d  = grant_c[1];
                    we_d    = grant_wr_c;
                    re_d    = !grant_wr_c;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = S_WAIT;
                if (done_match_c) begin
                    state_d     = S_RESP;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = write_q ? '0 : rdata;
                end
            end
            S_WAIT: begin
                if (done_match_c) begin
                    state_d     = S_RESP;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = write_q ? '0 : rdata;
                end else if (timeout_c) begin
                    state_d     = S_RESP;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = write_q ? '0 : ERR_DATA;
                    rsp_err_d   = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            write_q     <= 1'b0;
            last_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            re_q        <= re_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = grant_c;
    assign waddr     = addr_q;
    assign raddr     = addr_q;
    assign wdata     = wdata_q;
    assign we        = we_q;
    assign re        = re_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef CSR_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q, tocnt_q;

    // Saturating grant and timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            tocnt_q <= '0;
        end else begin
            if (grant_c[0] && gcnt0_q != 16'hFFFF) gcnt0_q <= gcnt0_q + 16'd1;
            if (grant_c[1] && gcnt1_q != 16'hFFFF) gcnt1_q <= gcnt1_q + 16'd1;
            if (timeout_c && tocnt_q != 16'hFFFF)  tocnt_q <= tocnt_q + 16'd1;
        end
    end

    assign grant_cnt0  = gcnt0_q;
    assign grant_cnt1  = gcnt1_q;
    assign timeout_cnt = tocnt_q;
`endif

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Self-checking bench for csr_access_arbiter (TIMEOUT overridden to 8).
// Directed vector table, hand-written reset/contention sequences, then
// randomized traffic against a transaction-schedule reference model.
module tb_csr_access_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam int          NEVER    = 1000;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] raddr;
    logic        re;
    logic [31:0] rdata;
    logic        rdone;
    logic        wdone;
`ifdef CSR_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [15:0] timeout_cnt;
`endif

    csr_access_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .ERR_DATA(ERR_DATA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .waddr    (waddr),
        .wdata    (wdata),
        .we       (we),
        .raddr    (raddr),
        .re       (re),
        .rdata    (rdata),
        .rdone    (rdone),
        .wdone    (wdone)
`ifdef CSR_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .timeout_cnt(timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int exp_g0;
    int exp_g1;
    int exp_to;

    typedef struct {
        bit          req;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        int          lat;
        logic [31:0] csr_data;
        bit          late_done;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive_idle();
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rdata     = '0;
        rdone     = 1'b0;
        wdone     = 1'b0;
    endtask

    task automatic pulse_reset();
        tick();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rst_ctrl", 64'({req_ready, rsp_valid, rsp_err, we, re}), 64'd0);
        chk("rst_addr", {waddr, raddr}, 64'd0);
        chk("rst_data", {wdata, rsp_rdata}, 64'd0);
        exp_g0 = 0;
        exp_g1 = 0;
        exp_to = 0;
    endtask

`ifdef CSR_ARB_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, "_grant_cnt0"}, 64'(grant_cnt0), 64'(exp_g0));
        chk({tag, "_grant_cnt1"}, 64'(grant_cnt1), 64'(exp_g1));
        chk({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'(exp_to));
    endtask
`endif

    // One directed transaction: accept, strobe, completion, response
    task automatic run_vec(input vec_t v);
        int         strobes;
        int         rsp_at;
        logic [1:0] onehot;
        onehot = v.req ? 2'b10 : 2'b01;
        tick();
        drive_idle();
        req_valid = onehot;
        req_write[v.req] = v.wr;
        if (v.req) begin
            req_addr[63:32]  = v.addr;
            req_wdata[63:32] = v.wdat;
        end else begin
            req_addr[31:0]  = v.addr;
            req_wdata[31:0] = v.wdat;
        end
        settle();
        chk("vec_ready", 64'(req_ready), 64'(onehot));
        strobes = 0;
        rsp_at  = -1;
        for (int k = 1; k <= 40 && rsp_at < 0; k++) begin
            tick();
            req_valid = 2'b00;
            rdone = 1'b0;
            wdone = 1'b0;
            rdata = $urandom;
            if (v.lat != NEVER && k == 1 + v.lat) begin
                if (v.wr) wdone = 1'b1;
                else begin
                    rdone = 1'b1;
                    rdata = v.csr_data;
                end
            end
            settle();
            if (we || re) begin
                strobes++;
                chk("vec_strobe_cycle", 64'(k), 64'd1);
                chk("vec_strobe_op", 64'({we, re}), v.wr ? 64'd2 : 64'd1);
                chk("vec_addr", 64'(v.wr ? waddr : raddr), 64'(v.addr));
                if (v.wr) chk("vec_wdata", 64'(wdata), 64'(v.wdat));
            end
            if (rsp_valid != 2'b00) begin
                rsp_at = k;
                chk("vec_rsp_bit", 64'(rsp_valid), 64'(onehot));
                chk("vec_rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
                chk("vec_rsp_err", 64'(rsp_err), 64'(v.exp_err));
            end
        end
        chk("vec_strobe_count", 64'(strobes), 64'd1);
        chk("vec_latency", 64'(rsp_at), 64'(v.exp_lat));
        if (v.req) exp_g1++; else exp_g0++;
        if (v.exp_err) exp_to++;
        if (v.late_done) begin
            tick();
            rdone = 1'b1;
            wdone = 1'b1;
            rdata = 32'hBAD0_BAD0;
            settle();
            chk("late_done_ignored", 64'({rsp_valid, we, re}), 64'd0);
            rdone = 1'b0;
            wdone = 1'b0;
        end
    endtask

    // Reset while a read is waiting; no response may ever appear for it
    task automatic reset_in_wait();
        tick();
        drive_idle();
        req_valid = 2'b01;
        req_addr[31:0] = 32'h40;
        settle();
        chk("rstw_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        pulse_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            settle();
            chk("rstw_no_rsp", 64'({rsp_valid, we, re}), 64'd0);
        end
    endtask

    // Both requesters continuously valid: grants must alternate starting with 0
    task automatic contention();
        int ngrant;
        int nrsp;
        int strobe_k;
        ngrant   = 0;
        nrsp     = 0;
        strobe_k = -10;
        for (int k = 0; k < 80 && nrsp < 4; k++) begin
            tick();
            req_valid = 2'b11;
            req_write = 2'b00;
            req_addr  = {32'h200, 32'h100};
            rdone     = (k == strobe_k + 1);
            rdata     = rdone ? 32'h1000 + 32'(nrsp) : 32'h0;
            settle();
            chk("ctn_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (req_ready != 2'b00) begin
                chk("ctn_order", 64'(req_ready), (ngrant % 2) ? 64'd2 : 64'd1);
                ngrant++;
            end
            if (re) begin
                strobe_k = k;
                chk("ctn_raddr", 64'(raddr), (ngrant % 2) ? 64'h100 : 64'h200);
            end
            if (rsp_valid != 2'b00) begin
                chk("ctn_rsp_bit", 64'(rsp_valid), (nrsp % 2) ? 64'd2 : 64'd1);
                chk("ctn_rsp_rdata", 64'(rsp_rdata), 64'(32'h1000 + 32'(nrsp)));
                nrsp++;
            end
        end
        chk("ctn_responses", 64'(nrsp), 64'd4);
        exp_g0 += 2;
        exp_g1 += 2;
        drive_idle();
    endtask

    // Randomized traffic against a transaction-schedule model
    task automatic random_traffic(input int ncycles);
        bit          busy;
        int          strobe_t;
        int          rsp_t;
        int          lat;
        bit          m_owner;
        bit          m_wr;
        bit          m_err;
        bit          m_last;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [31:0] m_rdval;
        logic [1:0]  v;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rsp;
        bit          exp_we;
        bit          exp_re;
        busy     = 1'b0;
        strobe_t = 0;
        rsp_t    = 0;
        lat      = 0;
        m_owner  = 1'b0;
        m_wr     = 1'b0;
        m_err    = 1'b0;
        m_last   = 1'b1;
        m_addr   = '0;
        m_wdata  = '0;
        m_rdval  = '0;
        for (int t = 0; t < ncycles; t++) begin
            tick();
            if (busy && t > rsp_t) busy = 1'b0;
            v         = 2'($urandom_range(0, 3));
            req_valid = v;
            req_write = 2'($urandom);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            rdata     = $urandom;
            rdone     = 1'b0;
            wdone     = 1'b0;
            if (busy && t >= strobe_t && t < rsp_t) begin
                if (t == strobe_t + lat) begin
                    if (m_wr) wdone = 1'b1;
                    else begin
                        rdone = 1'b1;
                        rdata = m_rdval;
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    if (m_wr) rdone = 1'b1;
                    else      wdone = 1'b1;
                end
            end else begin
                rdone = ($urandom_range(0, 6) == 0);
                wdone = ($urandom_range(0, 6) == 0);
            end
            exp_ready = 2'b00;
            if (!busy) begin
                if (v == 2'b01)      exp_ready = 2'b01;
                else if (v == 2'b10) exp_ready = 2'b10;
                else if (v == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
            end
            if (exp_ready != 2'b00) begin
                busy     = 1'b1;
                m_owner  = exp_ready[1];
                m_wr     = req_write[m_owner];
                m_addr   = m_owner ? req_addr[63:32] : req_addr[31:0];
                m_wdata  = m_owner ? req_wdata[63:32] : req_wdata[31:0];
                m_rdval  = $urandom;
                m_last   = m_owner;
                lat      = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT));
                m_err    = (lat > int'(TIMEOUT));
                strobe_t = t + 1;
                rsp_t    = strobe_t + (m_err ? int'(TIMEOUT) : lat) + 1;
                if (m_owner) exp_g1++; else exp_g0++;
                if (m_err) exp_to++;
            end
            exp_we  = busy && (t == strobe_t) && m_wr;
            exp_re  = busy && (t == strobe_t) && !m_wr;
            exp_rsp = (busy && t == rsp_t) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            settle();
            chk("rnd_ctrl", 64'({req_ready, we, re, rsp_valid}),
                64'({exp_ready, exp_we, exp_re, exp_rsp}));
            if (exp_we || exp_re) begin
                chk("rnd_addr", 64'(m_wr ? waddr : raddr), 64'(m_addr));
                if (m_wr) chk("rnd_wdata", 64'(wdata), 64'(m_wdata));
            end
            if (exp_rsp != 2'b00) begin
                chk("rnd_rsp_rdata", 64'(rsp_rdata),
                    64'(m_wr ? 32'h0 : (m_err ? ERR_DATA : m_rdval)));
                chk("rnd_rsp_err", 64'(rsp_err), 64'(m_err));
            end
        end
        drive_idle();
        for (int k = 0; k < int'(TIMEOUT) + 4; k++) tick();
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        exp_g0 = 0;
        exp_g1 = 0;
        exp_to = 0;
        rst    = 1'b1;
        drive_idle();

        vecs[0] = '{req: 1'b0, wr: 1'b0, addr: 32'h04, wdat: 32'h0, lat: 1,
                    csr_data: 32'h1234_5678, late_done: 1'b0,
                    exp_rdata: 32'h1234_5678, exp_err: 1'b0, exp_lat: 3};
        vecs[1] = '{req: 1'b1, wr: 1'b1, addr: 32'h10, wdat: 32'hA5A5_A5A5, lat: 0,
                    csr_data: 32'h0, late_done: 1'b0,
                    exp_rdata: 32'h0, exp_err: 1'b0, exp_lat: 2};
        vecs[2] = '{req: 1'b0, wr: 1'b0, addr: 32'h20, wdat: 32'h0, lat: 8,
                    csr_data: 32'hCAFE_F00D, late_done: 1'b0,
                    exp_rdata: 32'hCAFE_F00D, exp_err: 1'b0, exp_lat: 10};
        vecs[3] = '{req: 1'b1, wr: 1'b0, addr: 32'h30, wdat: 32'h0, lat: NEVER,
                    csr_data: 32'h0, late_done: 1'b1,
                    exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b1, exp_lat: 10};
        vecs[4] = '{req: 1'b0, wr: 1'b0, addr: 32'h08, wdat: 32'h0, lat: 2,
                    csr_data: 32'h0BAD_CAFE, late_done: 1'b0,
                    exp_rdata: 32'h0BAD_CAFE, exp_err: 1'b0, exp_lat: 4};

        pulse_reset();
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
`ifdef CSR_ARB_STATS_EN
        chk_stats("vec");
`endif
        reset_in_wait();
        contention();
`ifdef CSR_ARB_STATS_EN
        chk_stats("ctn");
`endif
        pulse_reset();
        random_traffic(2500);
`ifdef CSR_ARB_STATS_EN
        chk_stats("rnd");
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
